mem_port_arbiter: RTL and testbench

//  Shares the single CPU memory port between instruction fetch and data load/store.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data load/store.
// Latency: grant and memory access in the request cycle; read data routed back RD_LAT cycles later.
// Backpressure: requesters hold req until gnt; the loser waits. `define MEM_ARB_RR_EN selects round-robin.
module mem_port_arbiter #(
   parameter int AW         = 19,
   parameter int DW         = 19,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [DW-1:0] if_rdata_o,
   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic          dm_gnt_o,
   output logic          dm_rvalid_o,
   output logic [DW-1:0] dm_rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rd_data_i
);

   logic              w_if_win;   // fetch wins a contested cycle
   logic              w_if_gnt;
   logic              w_dm_gnt;
   logic              w_push_vld;
   logic [RD_LAT-1:0] r_tag_vld;  // index RD_LAT-1 is the exiting stage
   logic [RD_LAT-1:0] r_tag_own;  // 1 = data port owns the read, 0 = fetch

`ifdef MEM_ARB_RR_EN
   logic r_last_dm;

   assign w_if_win = r_last_dm;

   // remember the last winner so a contested cycle goes to the other side
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_last_dm <= 1'b1;
      else if (w_if_gnt | w_dm_gnt)
         r_last_dm <= w_dm_gnt;
   end
`else
   logic [7:0] r_starve_cnt;

   assign w_if_win = (r_starve_cnt == 8'(STARVE_MAX));

   // count data grants taken while fetch is kept waiting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_starve_cnt <= '0;
      else if (w_if_gnt | ~if_req_i)
         r_starve_cnt <= '0;
      else if (w_dm_gnt)
         r_starve_cnt <= r_starve_cnt + 8'd1;
   end
`endif

   assign w_if_gnt   = if_req_i & (~dm_req_i | w_if_win);
   assign w_dm_gnt   = dm_req_i & ~w_if_gnt;
   assign w_push_vld = w_if_gnt | (w_dm_gnt & ~dm_we_i);

   // drive grants and the memory bus from the winner; idle bus is all zero
   always_comb begin
      if_gnt_o    = w_if_gnt;
      dm_gnt_o    = w_dm_gnt;
      mem_req_o   = w_if_gnt | w_dm_gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_if_gnt) begin
         mem_addr_o = if_addr_i;
      end else if (w_dm_gnt) begin
         mem_we_o    = dm_we_i;
         mem_addr_o  = dm_addr_i;
         mem_wdata_o = dm_wdata_i;
      end
   end

   // shift owner tags along with the memory read latency; writes/idle push empty tags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tag_vld <= '0;
         r_tag_own <= '0;
      end else begin
         r_tag_vld[0] <= w_push_vld;
         r_tag_own[0] <= w_dm_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_own[i] <= r_tag_own[i-1];
         end
      end
   end

   // route the returning word to the owner of the exiting tag
   always_comb begin
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      dm_rvalid_o = 1'b0;
      dm_rdata_o  = '0;
      if (r_tag_vld[RD_LAT-1]) begin
         if (r_tag_own[RD_LAT-1]) begin
            dm_rvalid_o = 1'b1;
            dm_rdata_o  = mem_rd_data_i;
         end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rd_data_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed stimulus for mem_port_arbiter.
// A behavioural model predicts each cycle's bus and the in-order read responses;
// a negedge monitor pops the expectations and compares them to the DUT.
module tb_mem_port_arbiter;
   localparam int AW         = 19;
   localparam int DW         = 19;
   localparam int RD_LAT     = 3;
   localparam int STARVE_MAX = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          if_req_i = 1'b0;
   logic [AW-1:0] if_addr_i = '0;
   logic          if_gnt_o, if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          dm_req_i = 1'b0;
   logic          dm_we_i = 1'b0;
   logic [AW-1:0] dm_addr_i = '0;
   logic [DW-1:0] dm_wdata_i = '0;
   logic          dm_gnt_o, dm_rvalid_o;
   logic [DW-1:0] dm_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rd_data_i = '0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rd_data_i(mem_rd_data_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          ig;
      logic          dg;
      logic          rq;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
   } bus_t;

   typedef struct {
      int            due;
      logic          own_dm;
      logic [DW-1:0] d;
   } rsp_t;

   bus_t exp_bus[$];
   rsp_t exp_rsp[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   int   win = 0;           // 0 none, 1 fetch, 2 data (last modelled cycle)
   int   m_starve = 0;
   bit   m_last_dm = 1'b1;
   logic [DW-1:0] mpipe [RD_LAT];

   // memory contents are a fixed scramble of the address
   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      logic [AW-1:0] t;
      t = {a[6:0], a[AW-1:7]};
      return t ^ 19'h5A5A5;
   endfunction

   // memory model: returns the addressed word RD_LAT cycles after a read, junk otherwise
   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = RD_LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
      mpipe[0] = (mem_req_o && !mem_we_o) ? mem_val(mem_addr_o) : DW'($urandom);
      mem_rd_data_i = mpipe[RD_LAT-1];
   end

   // drive one cycle of requests, predict its outcome, then advance to next cycle
   task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
      bus_t b;
      rsp_t r;
      if_req_i = ir; if_addr_i = ia;
      dm_req_i = dr; dm_we_i = dwe; dm_addr_i = da; dm_wdata_i = dwd;
      win = 0;
      if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
         win = m_last_dm ? 1 : 2;
`else
         win = (m_starve == STARVE_MAX) ? 1 : 2;
`endif
      end else if (ir) win = 1;
      else if (dr) win = 2;
`ifdef MEM_ARB_RR_EN
      if (win != 0) m_last_dm = (win == 2);
`else
      if (win == 1 || !ir) m_starve = 0;
      else if (win == 2) m_starve = m_starve + 1;
`endif
      b = '0;
      if (win == 1) begin
         b.ig = 1'b1; b.rq = 1'b1; b.a = ia;
      end else if (win == 2) begin
         b.dg = 1'b1; b.rq = 1'b1; b.we = dwe; b.a = da; b.wd = dwd;
      end
      exp_bus.push_back(b);
      if (win == 1 || (win == 2 && !dwe)) begin
         r.due = cyc + RD_LAT;
         r.own_dm = (win == 2);
         r.d = mem_val(b.a);
         exp_rsp.push_back(r);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0);
   endtask

   // monitor: compare bus against the per-cycle prediction and responses against the in-order queue
   always @(negedge clk) begin
      if (mon_en) begin
         bus_t e;
         rsp_t r;
         logic [2*DW+1:0] exp_r;
         logic [2*DW+1:0] got_r;
         checks++;
         if (exp_bus.size() == 0) begin
            failures++;
            $display("FAIL bus_queue cyc=%0d no prediction available", cyc);
         end else begin
            e = exp_bus.pop_front();
            if ({if_gnt_o, dm_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== e) begin
               failures++;
               $display("FAIL mem_bus cyc=%0d got ig=%0b dg=%0b rq=%0b we=%0b a=%h wd=%h exp ig=%0b dg=%0b rq=%0b we=%0b a=%h wd=%h",
                        cyc, if_gnt_o, dm_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                        e.ig, e.dg, e.rq, e.we, e.a, e.wd);
            end
         end
         exp_r = '0;
         if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
            r = exp_rsp.pop_front();
            if (r.own_dm) exp_r = {1'b0, {DW{1'b0}}, 1'b1, r.d};
            else          exp_r = {1'b1, r.d, 1'b0, {DW{1'b0}}};
         end
         got_r = {if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o};
         checks++;
         if (got_r !== exp_r) begin
            failures++;
            $display("FAIL response cyc=%0d got if_rv=%0b if_rd=%h dm_rv=%0b dm_rd=%h exp if_rv=%0b if_rd=%h dm_rv=%0b dm_rd=%h",
                     cyc, if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o,
                     exp_r[2*DW+1], exp_r[2*DW:DW+1], exp_r[DW], exp_r[DW-1:0]);
         end
      end
   end

   initial begin
      bit            p_if, p_dm, p_we;
      logic [AW-1:0] p_ia, p_da;
      logic [DW-1:0] p_wd;
      int            sat_seen;

      for (int i = 0; i < RD_LAT; i++) mpipe[i] = '0;

      // reset state with no requests
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got req=%0b ig=%0b dg=%0b if_rv=%0b dm_rv=%0b exp all zero",
                  mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      mon_en = 1'b1;
      idle(4);

      // single fetch read
      step(1, 19'h00010, 0, 0, '0, '0);
      idle(RD_LAT + 1);

      // data write at top address: no response may follow
      step(0, '0, 1, 1, 19'h7FFFF, 19'h12345);
      idle(RD_LAT + 2);

      // both held high: starvation guard (or alternation) decides
      for (int k = 0; k < 3 * (STARVE_MAX + 1); k++)
         step(1, AW'(19'h00100 + k), 1, 0, AW'(19'h40000 + k), '0);
      idle(RD_LAT + 1);

      // back-to-back reads fetch, data, fetch
      step(1, 19'h01234, 0, 0, '0, '0);
      step(0, '0, 1, 0, 19'h2ABCD, '0);
      step(1, 19'h05678, 0, 0, '0, '0);
      idle(RD_LAT + 1);

      // reset with two reads outstanding: their responses must never appear
      step(1, 19'h0AAAA, 0, 0, '0, '0);
      step(0, '0, 1, 0, 19'h15555, '0);
      reset_n = 1'b0;
      exp_rsp.delete();
      m_starve = 0;
      m_last_dm = 1'b1;
      idle(2);
      reset_n = 1'b1;
      idle(RD_LAT + 3);

      // randomized traffic, requests held until granted
      p_if = 0; p_dm = 0; p_we = 0; p_ia = '0; p_da = '0; p_wd = '0;
      sat_seen = 0;
      for (int k = 0; k < 1500; k++) begin
         if (!p_if && $urandom_range(0, 99) < 60) begin
            p_if = 1; p_ia = AW'($urandom);
         end
         if (!p_dm && $urandom_range(0, 99) < 70) begin
            p_dm = 1; p_we = ($urandom_range(0, 2) == 0); p_da = AW'($urandom); p_wd = DW'($urandom);
         end
         if (p_if && p_dm && m_starve == STARVE_MAX) sat_seen++;
         step(p_if, p_ia, p_dm, p_we, p_da, p_wd);
         if (win == 1) p_if = 0;
         if (win == 2) p_dm = 0;
      end
      idle(RD_LAT + 2);
      mon_en = 1'b0;

      checks++;
      if (exp_rsp.size() != 0 || exp_bus.size() != 0) begin
         failures++;
         $display("FAIL drain got rsp_left=%0d bus_left=%0d exp 0 0", exp_rsp.size(), exp_bus.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
